// File: rtl/aes_io_stager_if.sv
// Bus bundle between the AES I/O stager, its word-stream producer/consumer and
// the combinational encryption core.
interface aes_io_stager_if;
  // Handshake: a word moves on a rising clock edge where valid and ready are
  // both high; valid never waits for ready, and data is stable while valid is
  // held without ready.
  logic [31:0]  in_data_i;
  logic         in_valid_i;
  logic         in_key_i;
  logic         in_ready_o;
  logic [127:0] pt_o;
  logic [255:0] key_o;
  logic [127:0] ct_i;
  logic [31:0]  out_data_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic         busy_o;

  modport master (
    output in_data_i, in_valid_i, in_key_i, ct_i, out_ready_i,
    input  in_ready_o, pt_o, key_o, out_data_o, out_valid_o, busy_o
  );

  modport slave (
    input  in_data_i, in_valid_i, in_key_i, ct_i, out_ready_i,
    output in_ready_o, pt_o, key_o, out_data_o, out_valid_o, busy_o
  );
endinterface

// File: rtl/aes_io_stager.sv
// Stages key/plaintext words into wide registers for a combinational AES core,
// waits for it to settle, then streams the ciphertext back out 32 bits at a time.
module aes_io_stager #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  aes_io_stager_if.slave    bus,
  output logic [2:0]        state_dbg_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_KEY = 3'd1,
    LOAD_PT  = 3'd2,
    SETTLE   = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t       state, state_nx;
  logic [2:0]   word_cnt, word_nx;
  logic [3:0]   settle_cnt, settle_nx;
  logic         ready_en;
  logic         accept;
  logic         in_ready, out_valid;
  logic         key_we, pt_we, ct_cap;
  logic [255:0] key_q;
  logic [127:0] pt_q;
  logic [127:0] ct_q;

  // ready_en keeps in_ready low until the first edge after reset release.
  assign accept = bus.in_valid_i & ready_en;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    word_nx   = word_cnt;
    settle_nx = settle_cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    key_we    = 1'b0;
    pt_we     = 1'b0;
    ct_cap    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = ready_en;
        if (accept) begin
          word_nx = 3'd1;
          if (bus.in_key_i) begin
            key_we   = 1'b1;
            state_nx = LOAD_KEY;
          end else begin
            pt_we    = 1'b1;
            state_nx = LOAD_PT;
          end
        end
      end
      LOAD_KEY: begin
        in_ready = ready_en;
        if (accept) begin
          key_we  = 1'b1;
          word_nx = word_cnt + 3'd1;
          if (word_cnt == 3'd7) begin
            state_nx = LOAD_PT;
            word_nx  = 3'd0;
          end
        end
      end
      LOAD_PT: begin
        in_ready = ready_en;
        if (accept) begin
          pt_we   = 1'b1;
          word_nx = word_cnt + 3'd1;
          if (word_cnt == 3'd3) begin
            state_nx  = SETTLE;
            word_nx   = 3'd0;
            settle_nx = 4'd0;
          end
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          ct_cap   = 1'b1;
          state_nx = DRAIN;
          word_nx  = 3'd0;
        end else begin
          settle_nx = settle_cnt + 4'd1;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (bus.out_ready_i) begin
          word_nx = word_cnt + 3'd1;
          if (word_cnt == 3'd3) begin
            state_nx = IDLE;
            word_nx  = 3'd0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Word n lands MSW first: index 7-n (key) or 3-n (plaintext) is ~n.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ready_en   <= 1'b0;
      word_cnt   <= 3'd0;
      settle_cnt <= 4'd0;
      key_q      <= '0;
      pt_q       <= '0;
      ct_q       <= '0;
    end else begin
      ready_en   <= 1'b1;
      word_cnt   <= word_nx;
      settle_cnt <= settle_nx;
      if (key_we) key_q[{~word_cnt, 5'b0} +: 32]     <= bus.in_data_i;
      if (pt_we)  pt_q[{~word_cnt[1:0], 5'b0} +: 32] <= bus.in_data_i;
      if (ct_cap) ct_q <= bus.ct_i;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = ct_q[{~word_cnt[1:0], 5'b0} +: 32];
  assign bus.key_o       = key_q;
  assign bus.pt_o        = pt_q;
  assign bus.busy_o      = (state != IDLE);
  assign state_dbg_o     = state;

endmodule

// File: tb/tb_aes_io_stager.sv
// Directed bench for aes_io_stager: FIPS-197 AES-256 vector through a stand-in
// core, stalls, settle latency for several SETTLE_CYCLES, and mid-job resets.
module tb_aes_io_stager;

  localparam logic [255:0] KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] MASK = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic       clk;
  logic       reset_n;
  logic [2:0] state0, state1, state2;
  int         compared = 0;
  int         failed   = 0;
  int         low0 = 0, low1 = 0, low2 = 0;
  logic [31:0] exp_q[$];

  aes_io_stager_if bus0();
  aes_io_stager_if bus1();
  aes_io_stager_if bus2();

  aes_io_stager dut0 (.clk_i(clk), .reset_n_i(reset_n), .bus(bus0), .state_dbg_o(state0));
  aes_io_stager #(.SETTLE_CYCLES(1))  dut1 (.clk_i(clk), .reset_n_i(reset_n), .bus(bus1), .state_dbg_o(state1));
  aes_io_stager #(.SETTLE_CYCLES(15)) dut2 (.clk_i(clk), .reset_n_i(reset_n), .bus(bus2), .state_dbg_o(state2));

  // Stand-in encryption core: the real AES-256 answer for the FIPS vector,
  // an easily predicted mix of key and plaintext for everything else.
  function automatic logic [127:0] core(input logic [255:0] k, input logic [127:0] p);
    if (k == KEY && p == PT) return CT;
    return p ^ k[255:128] ^ k[127:0] ^ MASK;
  endfunction

  assign bus0.ct_i = core(bus0.key_o, bus0.pt_o);
  assign bus1.ct_i = core(bus1.key_o, bus1.pt_o);
  assign bus2.ct_i = core(bus2.key_o, bus2.pt_o);

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Cycles with in_ready low while out of reset, per DUT.
  always @(posedge clk) begin
    if (reset_n && !bus0.in_ready_o) low0++;
    if (reset_n && !bus1.in_ready_o) low1++;
    if (reset_n && !bus2.in_ready_o) low2++;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_word(input logic [31:0] d, input logic k);
    int t;
    bus0.in_data_i  = d;
    bus0.in_key_i   = k;
    bus0.in_valid_i = 1'b1;
    t = 0;
    while (!bus0.in_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", bus0.in_ready_o, 1);
    @(posedge clk);
    @(negedge clk);
    bus0.in_valid_i = 1'b0;
  endtask

  task automatic gap(input int max_gap);
    if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
  endtask

  task automatic send_job(input bit with_key, input logic [255:0] k, input logic [127:0] p,
                          input int max_gap);
    if (with_key)
      for (int i = 0; i < 8; i++) begin
        gap(max_gap);
        send_word(k[255-32*i -: 32], (i == 0));
      end
    for (int i = 0; i < 4; i++) begin
      gap(max_gap);
      // in_key only matters on the first word of a job
      send_word(p[127-32*i -: 32], with_key ? 1'b1 : (i != 0));
    end
  endtask

  task automatic drain(input logic [127:0] exp, input int stall_word);
    int t;
    logic [31:0] w_exp;
    for (int w = 0; w < 4; w++) exp_q.push_back(exp[127-32*w -: 32]);
    for (int w = 0; w < 4; w++) begin
      t = 0;
      while (!bus0.out_valid_o && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("out_valid_wait", bus0.out_valid_o, 1);
      w_exp = exp_q.pop_front();
      if (w == stall_word) begin
        bus0.out_ready_i = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_hold", bus0.out_data_o, w_exp);
        end
        bus0.out_ready_i = 1'b1;
      end
      chk("ct_word", bus0.out_data_o, w_exp);
      @(posedge clk);
      @(negedge clk);
    end
    chk("busy_after_drain", bus0.busy_o, 0);
    chk("state_after_drain", state0, 3'd0);
  endtask

  task automatic quiet_after_reset();
    int seen;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus0.out_valid_o) seen++;
    end
    chk("no_out_after_reset", seen, 0);
    chk("idle_after_reset", state0, 3'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s0, s1, s2;
    reset_n = 1'b1;
    bus0.in_data_i = '0; bus0.in_valid_i = 1'b0; bus0.in_key_i = 1'b0; bus0.out_ready_i = 1'b1;
    bus1.in_data_i = '0; bus1.in_valid_i = 1'b0; bus1.in_key_i = 1'b0; bus1.out_ready_i = 1'b1;
    bus2.in_data_i = '0; bus2.in_valid_i = 1'b0; bus2.in_key_i = 1'b0; bus2.out_ready_i = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_in_ready", bus0.in_ready_o, 0);
    chk("rst_out_valid", bus0.out_valid_o, 0);
    chk("rst_busy", bus0.busy_o, 0);
    chk("rst_key", bus0.key_o, 0);
    chk("rst_pt", bus0.pt_o, 0);
    chk("rst_state", state0, 3'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 chk("ready_before_edge", bus0.in_ready_o, 0);
    @(negedge clk);
    chk("ready_after_edge", bus0.in_ready_o, 1);

    // Settle latency on the SETTLE_CYCLES=1 and =15 instances
    for (int i = 0; i < 4; i++) begin
      bus1.in_data_i = PT[127-32*i -: 32]; bus1.in_valid_i = 1'b1;
      bus2.in_data_i = PT[127-32*i -: 32]; bus2.in_valid_i = 1'b1;
      @(negedge clk);
    end
    bus1.in_valid_i = 1'b0;
    bus2.in_valid_i = 1'b0;
    s1 = low1;
    s2 = low2;
    chk("s1_in_settle", state1, 3'd3);
    repeat (30) @(negedge clk);
    chk("s1_ready_low_cycles", low1 - s1, 5);
    chk("s15_ready_low_cycles", low2 - s2, 19);
    chk("s1_back_idle", state1, 3'd0);
    chk("s15_back_idle", state2, 3'd0);

    // Job A: full key load, FIPS vector
    send_job(1'b1, KEY, PT, 0);
    s0 = low0;
    chk("jobA_key", bus0.key_o, KEY);
    chk("jobA_pt", bus0.pt_o, PT);
    chk("jobA_settle", state0, 3'd3);
    chk("jobA_ready_low", bus0.in_ready_o, 0);
    chk("jobA_no_valid_settle", bus0.out_valid_o, 0);
    drain(CT, -1);
    chk("jobA_ready_low_cycles", low0 - s0, 6);

    // Job B: reuse stored key, only four input words
    send_job(1'b0, KEY, PT, 0);
    chk("jobB_settle_after_4", state0, 3'd3);
    chk("jobB_key_kept", bus0.key_o, KEY);
    drain(CT, -1);

    // Job C: input gaps and a 3-cycle output stall on word 2
    send_job(1'b1, KEY, PT, 3);
    s0 = low0;
    drain(CT, 2);
    chk("jobC_ready_low_cycles", low0 - s0, 9);

    // Reset during LOAD_PT word 2
    send_word(PT[127:96], 1'b0);
    send_word(PT[95:64], 1'b0);
    chk("pre_rst_load_pt", state0, 3'd2);
    bus0.in_data_i  = PT[63:32];
    bus0.in_valid_i = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("rstpt_state", state0, 3'd0);
    chk("rstpt_pt", bus0.pt_o, 0);
    chk("rstpt_key", bus0.key_o, 0);
    chk("rstpt_ready", bus0.in_ready_o, 0);
    chk("rstpt_busy", bus0.busy_o, 0);
    bus0.in_valid_i = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    quiet_after_reset();

    // Reset during DRAIN word 1
    send_job(1'b1, KEY, PT, 0);
    while (!bus0.out_valid_o) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("drain_word1", bus0.out_data_o, CT[95:64]);
    #2 reset_n = 1'b0;
    #1;
    chk("rstdr_out_valid", bus0.out_valid_o, 0);
    chk("rstdr_out_data", bus0.out_data_o, 0);
    chk("rstdr_key", bus0.key_o, 0);
    chk("rstdr_busy", bus0.busy_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    quiet_after_reset();

    // First job after reset without a key: all-zero key
    send_job(1'b0, KEY, PT, 0);
    chk("zero_key", bus0.key_o, 0);
    drain(PT ^ MASK, -1);

    // Full job after reset recovers the FIPS result
    send_job(1'b1, KEY, PT, 1);
    drain(CT, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
